// File: rtl/baccarat_pkg.sv
// Shared types and rule constants for the baccarat round controller.
// card_value folds 10/J/Q/K (and the empty code 0) to zero points.
package baccarat_pkg;

   typedef enum logic [3:0] {
      DEAL_P1,
      DEAL_D1,
      DEAL_P2,
      DEAL_D2,
      CHECK,
      DRAW_P3,
      BANKER_CHK,
      DRAW_D3,
      FINAL,
      DONE
   } state_t;

   localparam logic [3:0] NATURAL_MIN       = 4'd8;
   localparam logic [3:0] PLAYER_STAND_MIN  = 4'd6;
   localparam logic [3:0] DEALER_NEVER_DRAW = 4'd7;

   function automatic logic [3:0] card_value(input logic [3:0] card);
      return (card >= 4'd10) ? 4'd0 : card;
   endfunction

endpackage

// File: rtl/baccarat_dealer_fsm_banker_draw_rule.sv
// Banker tableau: decides whether the dealer takes a third card once the
// player has drawn, from the dealer's two-card score and the player's third card.
module banker_draw_rule
   import baccarat_pkg::*;
(
   input  logic [3:0] dscore,
   input  logic [3:0] pcard3,
   output logic       draw
);

   logic [3:0] v;

   always_comb begin
      v    = card_value(pcard3);
      draw = 1'b0;
      if (dscore < DEALER_NEVER_DRAW) begin
         case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/baccarat_dealer_fsm.sv
// One-round baccarat controller: strobes card loads in dealing order, applies
// the third-card rules against scorehand feedback and latches the result.
module baccarat_dealer_fsm
   import baccarat_pkg::*;
(
   input  logic       slow_clock,
   input  logic       reset,
   input  logic [3:0] pscore,
   input  logic [3:0] dscore,
   input  logic [3:0] pcard3,
   output logic       load_pcard1,
   output logic       load_pcard2,
   output logic       load_pcard3,
   output logic       load_dcard1,
   output logic       load_dcard2,
   output logic       load_dcard3,
   output logic       player_win_light,
   output logic       dealer_win_light,
   output logic       done
);

   state_t state, next_state;
   logic   banker_draw;

   banker_draw_rule u_banker_draw_rule (
      .dscore (dscore),
      .pcard3 (pcard3),
      .draw   (banker_draw)
   );

   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) state <= DEAL_P1;
      else       state <= next_state;
   end

   always_comb begin
      next_state = DEAL_P1;
      case (state)
         DEAL_P1:    next_state = DEAL_D1;
         DEAL_D1:    next_state = DEAL_P2;
         DEAL_P2:    next_state = DEAL_D2;
         DEAL_D2:    next_state = CHECK;
         CHECK: begin
            if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) next_state = FINAL;
            else if (pscore < PLAYER_STAND_MIN)                 next_state = DRAW_P3;
            else if (dscore < PLAYER_STAND_MIN)                 next_state = DRAW_D3;
            else                                                next_state = FINAL;
         end
         DRAW_P3:    next_state = BANKER_CHK;
         BANKER_CHK: next_state = banker_draw ? DRAW_D3 : FINAL;
         DRAW_D3:    next_state = FINAL;
         FINAL:      next_state = DONE;
         DONE:       next_state = DONE;
         default:    next_state = DEAL_P1;
      endcase
   end

   // Lights update only while leaving FINAL, so DONE holds them until reset.
   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         player_win_light <= 1'b0;
         dealer_win_light <= 1'b0;
      end else if (state == FINAL) begin
         player_win_light <= (pscore >= dscore);
         dealer_win_light <= (dscore >= pscore);
      end
   end

   // Reset parks the FSM in DEAL_P1, so strobes are gated to stay quiet during it.
   always_comb begin
      load_pcard1 = 1'b0;
      load_pcard2 = 1'b0;
      load_pcard3 = 1'b0;
      load_dcard1 = 1'b0;
      load_dcard2 = 1'b0;
      load_dcard3 = 1'b0;
      done        = 1'b0;
      if (!reset) begin
         case (state)
            DEAL_P1: load_pcard1 = 1'b1;
            DEAL_D1: load_dcard1 = 1'b1;
            DEAL_P2: load_pcard2 = 1'b1;
            DEAL_D2: load_dcard2 = 1'b1;
            DRAW_P3: load_pcard3 = 1'b1;
            DRAW_D3: load_dcard3 = 1'b1;
            DONE:    done        = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_baccarat_dealer_fsm.sv
// Bench: models card registers and scorehands, plays directed and random
// rounds, and scoreboards the strobe schedule, latency and lights per cycle.
module tb_baccarat_dealer_fsm;

   typedef struct packed {
      logic [15:0][5:0] ld;
      logic [4:0]       lat;
      logic             pw;
      logic             dw;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] pscore, dscore, pcard3;
   logic       lp1, lp2, lp3, ld1, ld2, ld3, pw, dw, done;
   logic [5:0] loads;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   exp_t cur;
   bit   active = 0;
   int   edges  = 0;
   int   pcards[3];
   int   dcards[3];
   logic [3:0] preg[3];
   logic [3:0] dreg[3];
   // bit v set in entry d: dealer holding d draws when player's third card is worth v
   int   bank_mask[8] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF, 10'h0FC, 10'h0F0, 10'h0C0, 0};

   always #5 clk = ~clk;

   baccarat_dealer_fsm dut (
      .slow_clock       (clk),
      .reset            (rst),
      .pscore           (pscore),
      .dscore           (dscore),
      .pcard3           (pcard3),
      .load_pcard1      (lp1),
      .load_pcard2      (lp2),
      .load_pcard3      (lp3),
      .load_dcard1      (ld1),
      .load_dcard2      (ld2),
      .load_dcard3      (ld3),
      .player_win_light (pw),
      .dealer_win_light (dw),
      .done             (done)
   );

   function automatic int pv(input int c);
      return (c >= 10) ? 0 : c;
   endfunction

   function automatic logic [3:0] hand(input int a, input int b, input int c);
      return 4'((pv(a) + pv(b) + pv(c)) % 10);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            preg[i] <= 4'd0;
            dreg[i] <= 4'd0;
         end
      end else begin
         if (lp1) preg[0] <= 4'(pcards[0]);
         if (lp2) preg[1] <= 4'(pcards[1]);
         if (lp3) preg[2] <= 4'(pcards[2]);
         if (ld1) dreg[0] <= 4'(dcards[0]);
         if (ld2) dreg[1] <= 4'(dcards[1]);
         if (ld3) dreg[2] <= 4'(dcards[2]);
      end
   end

   always_comb begin
      pscore = hand(preg[0], preg[1], preg[2]);
      dscore = hand(dreg[0], dreg[1], dreg[2]);
      pcard3 = preg[2];
   end

   assign loads = {lp1, ld1, lp2, ld2, lp3, ld3};

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input int p1, input int p2, input int p3,
                                  input int d1, input int d2, input int d3);
      exp_t e;
      int   ps, ds, v;
      bit   pd, dd;
      e  = '0;
      pd = 1'b0;
      dd = 1'b0;
      ps = (pv(p1) + pv(p2)) % 10;
      ds = (pv(d1) + pv(d2)) % 10;
      if (ps < 8 && ds < 8) begin
         if (ps <= 5) begin
            pd = 1'b1;
            v  = pv(p3);
            ps = (ps + v) % 10;
            dd = bank_mask[ds][v];
         end else begin
            dd = (ds <= 5);
         end
         if (dd) ds = (ds + pv(d3)) % 10;
      end
      e.ld[0] = 6'b100000;
      e.ld[1] = 6'b010000;
      e.ld[2] = 6'b001000;
      e.ld[3] = 6'b000100;
      if (pd) e.ld[5] = 6'b000010;
      if (dd) e.ld[pd ? 7 : 5] = 6'b000001;
      e.lat = 5'(6 + 2 * int'(pd) + int'(dd));
      e.pw  = (ps >= ds);
      e.dw  = (ds >= ps);
      return e;
   endfunction

   // Monitor: one expectation per round, popped on the first cycle out of reset.
   always @(negedge clk) begin
      if (rst) begin
         check("reset_outs", {loads, pw, dw, done}, 0);
         active = 0;
         edges  = 0;
      end else begin
         if (!active) begin
            if (exp_q.size() == 0) check("queue_empty", exp_q.size(), 1);
            else begin
               cur    = exp_q.pop_front();
               active = 1;
               edges  = 0;
            end
         end
         if (active) begin
            check("onehot", int'($countones(loads) <= 1), 1);
            check("loads", loads, (edges < 16) ? cur.ld[edges] : 6'd0);
            if (edges < int'(cur.lat)) check("pre_done", {done, pw, dw}, 0);
            else                       check("result", {done, pw, dw}, {1'b1, cur.pw, cur.dw});
            edges++;
         end
      end
   end

   task automatic setup(input int p1, input int p2, input int p3,
                        input int d1, input int d2, input int d3);
      @(posedge clk);
      #2 rst = 1'b1;
      pcards = '{p1, p2, p3};
      dcards = '{d1, d2, d3};
      exp_q.push_back(model(p1, p2, p3, d1, d2, d3));
      @(posedge clk);
      #3 rst = 1'b0;
   endtask

   task automatic play(input int p1, input int p2, input int p3,
                       input int d1, input int d2, input int d3);
      int n;
      setup(p1, p2, p3, d1, d2, d3);
      n = 0;
      while (!done && n < 30) begin
         @(posedge clk);
         #2 n++;
      end
      if (!done) check("done_timeout", done, 1);
      repeat (3) @(posedge clk);
   endtask

   task automatic abort_in_draw_p3(input int p1, input int p2, input int p3,
                                   input int d1, input int d2, input int d3);
      int n;
      setup(p1, p2, p3, d1, d2, d3);
      n = 0;
      while (!lp3 && n < 20) begin
         @(posedge clk);
         #2 n++;
      end
      if (!lp3) check("p3_timeout", lp3, 1);
      rst = 1'b1;
      #1 check("abort_outs", {loads, pw, dw, done}, 0);
      play(p1, p2, p3, d1, d2, d3);
   endtask

   initial begin
      #1 rst = 1'b1;
      play(3, 5, 9, 2, 2, 9);      // player natural 8
      play(2, 3, 4, 10, 7, 5);     // player draws, dealer stands on 7
      play(1, 2, 6, 2, 2, 13);     // both draw, 9 vs 4
      play(13, 7, 1, 3, 2, 3);     // player stands on 7, dealer draws to 8
      play(4, 2, 1, 4, 2, 1);      // both stand on 6, tie
      play(10, 13, 8, 1, 2, 4);    // dealer 3 vs player third card 8: stands
      play(5, 13, 8, 9, 10, 2);    // dealer natural 9
      abort_in_draw_p3(1, 2, 6, 2, 2, 13);
      for (int i = 0; i < 40; i++)
         play($urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13),
              $urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13));
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
